// File: rtl/lr35902_iobus_pkg.sv
// rtl/lr35902_iobus_pkg.sv - shared FSM encoding and default geometry for the LR35902 I/O bus controller
package lr35902_iobus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int DEF_NUM_SLV = 9;
    localparam int DEF_ADR_W   = 8;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 15;

    // Slot 0 sits in the least significant byte.
    localparam logic [DEF_NUM_SLV*DEF_ADR_W-1:0] DEF_SLV_BASE =
        {8'h01, 8'h00, 8'h04, 8'h10, 8'h40, 8'h50, 8'h80, 8'h0F, 8'hFF};
    localparam logic [DEF_NUM_SLV*DEF_ADR_W-1:0] DEF_SLV_MASK =
        {8'hFE, 8'hFF, 8'hFC, 8'hF0, 8'hF0, 8'hFF, 8'h80, 8'hFF, 8'hFF};

endpackage

// File: rtl/lr35902_iobus_dec.sv
// rtl/lr35902_iobus_dec.sv - masked priority address decoder, lowest matching slot wins
module lr35902_iobus_dec
    import lr35902_iobus_pkg::*;
#(
    parameter int                         NUM_SLV  = DEF_NUM_SLV,
    parameter int                         ADR_W    = DEF_ADR_W,
    parameter logic [NUM_SLV*ADR_W-1:0]   SLV_BASE = DEF_SLV_BASE,
    parameter logic [NUM_SLV*ADR_W-1:0]   SLV_MASK = DEF_SLV_MASK
) (
    input  logic [ADR_W-1:0]   adr,
    output logic [NUM_SLV-1:0] sel,
    output logic               hit
);

    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (!hit && ((adr & SLV_MASK[i*ADR_W +: ADR_W]) ==
                         (SLV_BASE[i*ADR_W +: ADR_W] & SLV_MASK[i*ADR_W +: ADR_W]))) begin
                sel[i] = 1'b1;
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lr35902_iobus_ctl.sv
// rtl/lr35902_iobus_ctl.sv - LR35902 I/O bus controller; optional ready timeout via LR35902_IOBUS_TIMEOUT_EN
module lr35902_iobus_ctl
    import lr35902_iobus_pkg::*;
#(
    parameter int                         NUM_SLV  = DEF_NUM_SLV,
    parameter int                         ADR_W    = DEF_ADR_W,
    parameter int                         DATA_W   = DEF_DATA_W,
    parameter logic [NUM_SLV*ADR_W-1:0]   SLV_BASE = DEF_SLV_BASE,
    parameter logic [NUM_SLV*ADR_W-1:0]   SLV_MASK = DEF_SLV_MASK,
    parameter int                         TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADR_W-1:0]          adr,
    input  logic                      req,
    input  logic                      we,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         rdata,
    output logic                      ack,
    output logic                      err,
    output logic [NUM_SLV-1:0]        cs,
    output logic                      slv_we,
    output logic [DATA_W-1:0]         slv_wdata,
    input  logic [NUM_SLV*DATA_W-1:0] slv_rdata,
    input  logic [NUM_SLV-1:0]        slv_ready
);

    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t              state, state_nxt;
    logic [NUM_SLV-1:0]  dec_sel;
    logic                dec_hit;
    logic [DATA_W-1:0]   sel_rdata;
    logic                sel_ready;
    logic [CNT_W-1:0]    wait_cnt;
    logic                timeout_hit;
    logic                access_end;

    lr35902_iobus_dec #(
        .NUM_SLV  (NUM_SLV),
        .ADR_W    (ADR_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .adr (adr),
        .sel (dec_sel),
        .hit (dec_hit)
    );

    // cs is one-hot, so OR-ing the gated lanes is the mux.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            sel_rdata = sel_rdata | (slv_rdata[i*DATA_W +: DATA_W] & {DATA_W{cs[i]}});
        end
    end

    assign sel_ready = |(cs & slv_ready);

`ifdef LR35902_IOBUS_TIMEOUT_EN
    logic err_q;
    assign timeout_hit = (cs != '0) && !sel_ready && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // An unmapped access has cs==0 and finishes after a single ACCESS cycle.
    assign access_end = (state == ST_ACCESS) && ((cs == '0) || sel_ready || timeout_hit);

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (req) state_nxt = ST_ACCESS;
            ST_ACCESS: if (access_end) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ack = (state == ST_DONE);
`ifdef LR35902_IOBUS_TIMEOUT_EN
        err = (state == ST_DONE) && err_q;
`else
        err = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cs        <= '0;
            slv_we    <= 1'b0;
            slv_wdata <= '0;
            rdata     <= '1;
            wait_cnt  <= '0;
`ifdef LR35902_IOBUS_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
        end else if (state == ST_IDLE && req) begin
            cs        <= dec_hit ? dec_sel : '0;
            slv_we    <= we;
            slv_wdata <= wdata;
            wait_cnt  <= '0;
        end else if (state == ST_ACCESS) begin
            if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
            if (access_end) begin
                cs     <= '0;
                slv_we <= 1'b0;
                // Writes, open-bus and timed-out accesses all read back all-ones.
                rdata  <= (sel_ready && !slv_we) ? sel_rdata : '1;
`ifdef LR35902_IOBUS_TIMEOUT_EN
                err_q  <= timeout_hit;
`endif
            end
        end
    end

endmodule

// File: doc/lr35902_iobus_ctl.md
LR35902_IOBUS_CTL -- requirements
Module: lr35902_iobus_ctl

Interface
REQ-001 SHALL have parameter NUM_SLV, default 9: number of slave windows.
REQ-002 SHALL have parameter ADR_W, default 8: I/O offset width (0xFF00+adr).
REQ-003 SHALL have parameter DATA_W, default 8: data width.
REQ-004 SHALL have parameter SLV_BASE, default per-slot 0xFF/0x0F/0x80/0x50/0x40/0x10/0x04/0x00/0x01: packed NUM_SLV*ADR_W base addresses.
REQ-005 SHALL have parameter SLV_MASK, default 0xFF/0xFF/0x80/0xFF/0xF0/0xF0/0xFC/0xFF/0xFE: packed NUM_SLV*ADR_W care-masks; a 1 bit is compared.
REQ-006 SHALL have parameter TIMEOUT, default 15: maximum wait cycles for slave ready.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 reset  input  1  reset, synchronous, active-low.
REQ-009 adr  input  ADR_W  CPU I/O offset, sampled on req.
REQ-010 req  input  1  one-cycle access request strobe.
REQ-011 we  input  1  write when 1, read when 0, sampled on req.
REQ-012 wdata  input  DATA_W  write data, sampled on req.
REQ-013 rdata  output  DATA_W  read data, valid while ack=1.
REQ-014 ack  output  1  one-cycle access-complete pulse.
REQ-015 err  output  1  one-cycle pulse with ack on timeout.
REQ-016 cs  output  NUM_SLV  registered one-hot slave select.
REQ-017 slv_we  output  1  registered write strobe qualifier.
REQ-018 slv_wdata  output  DATA_W  registered write data.
REQ-019 slv_rdata  input  NUM_SLV*DATA_W  packed slave read data.
REQ-020 slv_ready  input  NUM_SLV  per-slave completion.

Function
REQ-021 Slot i SHALL match when (adr & mask_i) == (base_i & mask_i); lowest matching index SHALL win.
REQ-022 FSM states SHALL be IDLE, ACCESS, DONE.
REQ-023 IDLE + req SHALL latch adr/we/wdata, register cs one-hot (or all-zero if unmapped), go to ACCESS next cycle.
REQ-024 req outside IDLE SHALL be ignored; no queueing.
REQ-025 ACCESS with selected slv_ready=1 SHALL capture that slave's slv_rdata into rdata, drop cs, go to DONE.
REQ-026 ACCESS with no slot selected SHALL set rdata all-ones (open bus), go to DONE after one ACCESS cycle.
REQ-027 DONE SHALL assert ack for exactly one cycle then return to IDLE; minimum latency req->ack is 2 cycles.
REQ-028 slv_ready of non-selected slaves SHALL be ignored.
REQ-029 Writes SHALL also return rdata all-ones on ack.
REQ-030 Wait counter SHALL count ACCESS cycles, saturating, cleared on entering ACCESS.
REQ-031 rdata SHALL hold its value until the next ack.

Reset
REQ-032 reset=0 at a clock edge SHALL force IDLE, cs=0, slv_we=0, slv_wdata=0, rdata=all-ones, ack=0, err=0, counter=0.
REQ-033 Reset mid-access SHALL abort with no ack and no err.

Configuration
REQ-034 Macro LR35902_IOBUS_TIMEOUT_EN defined: counter reaching TIMEOUT in ACCESS without ready SHALL drop cs, set rdata all-ones, go to DONE with err=1 alongside ack.
REQ-035 Macro undefined: ACCESS SHALL wait indefinitely for ready; err SHALL be tied 0.

Structure
REQ-036 Package lr35902_iobus_pkg SHALL hold the FSM state encoding and default ADR_W/DATA_W/TIMEOUT constants.
REQ-037 Sub-module lr35902_iobus_dec SHALL implement the combinational masked priority decoder (adr -> one-hot, hit).

Verification
REQ-038 Read adr=0x0F, slot1 ready same cycle, slv_rdata=0xE1 -> cs=0b000000010 for 1 cycle, ack 2 cycles after req, rdata=0xE1.
REQ-039 adr=0xFF matches slots 0 and 2 -> only cs[0] asserted.
REQ-040 Read adr=0x4C with PPU mask 0xF0 -> cs[4]; read adr=0x03 (unmapped) -> cs=0, ack after 2 cycles, rdata=0xFF.
REQ-041 TIMEOUT_EN, TIMEOUT=15, slot never ready -> ack and err together after 15 ACCESS cycles, rdata=0xFF; without macro, no ack after 100 cycles.
REQ-042 Write adr=0x05 wdata=0x5A, slot6 ready after 3 cycles -> slv_we=1, slv_wdata=0x5A held while cs[6]; second req during ACCESS ignored.
REQ-043 reset=0 during ACCESS -> next cycle cs=0, ack=0, state IDLE; new req then completes normally.
